// File: rtl/synth_pkg.sv
// Shared constants for the synth voice path.
//   NOTE_REST            : note code meaning "no note"
//   DEF_SAMPLE_W/NOTE_W  : default sample and note-code widths
//   MIX_FIXED/ADAPTIVE   : mixer attenuation modes
//   adaptive_shift()     : ceil(log2(max(cnt,1))), the adaptive attenuation shift
package synth_pkg;
  localparam int NOTE_REST    = 0;
  localparam int DEF_SAMPLE_W = 32;
  localparam int DEF_NOTE_W   = 5;
  localparam int MIX_FIXED    = 0;
  localparam int MIX_ADAPTIVE = 1;

  function automatic int adaptive_shift(input int cnt);
    int s;
    s = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) < cnt) s = k + 1;
    return s;
  endfunction
endpackage

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
//   clk, reset (sync, active-high), enable (freeze when low)
//   note_on/note_on_code, note_off/note_off_code : one-cycle strobes, code 0 ignored
//   voice_note   : per-voice note, voice i at [i*NOTE_W +: NOTE_W], 0 when idle
//   voice_active : per-voice busy mask
//   active_count : number of busy voices
// note_off is applied before note_on so a voice released this cycle can be
// reused by the note_on of the same cycle.
module voice_allocator import synth_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = DEF_NOTE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         note_on,
  input  logic [NOTE_W-1:0]            note_on_code,
  input  logic                         note_off,
  input  logic [NOTE_W-1:0]            note_off_code,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [$clog2(NUM_VOICES):0]  active_count
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int AGE_W = IDX_W + 1;
  localparam logic [AGE_W-1:0]  AGE_MAX = '1;
  localparam logic [NOTE_W-1:0] REST    = NOTE_W'(NOTE_REST);

  logic [NUM_VOICES-1:0]             act_q, act_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  age_q, age_d;
  logic [IDX_W:0]                    cnt_q, cnt_d;
  logic                              hit, free;
  logic [IDX_W-1:0]                  hit_idx, free_idx, old_idx, tgt;

  always_comb begin
    act_d    = act_q;
    note_d   = note_q;
    age_d    = age_q;
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    tgt      = '0;
    cnt_d    = '0;
    if (note_off && note_off_code != REST)
      for (int i = 0; i < NUM_VOICES; i++)
        if (act_d[i] && note_d[i] == note_off_code) begin
          act_d[i]  = 1'b0;
          note_d[i] = '0;
          age_d[i]  = '0;
        end
    if (note_on && note_on_code != REST) begin
      // descending scans so the lowest index wins
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
        if (act_d[i] && note_d[i] == note_on_code) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
        if (!act_d[i]) begin
          free     = 1'b1;
          free_idx = IDX_W'(i);
        end
      end
      // strict '>' keeps the lowest index on age ties
      for (int i = 1; i < NUM_VOICES; i++)
        if (age_d[i] > age_d[old_idx]) old_idx = IDX_W'(i);
      if (hit) begin
        age_d[hit_idx] = '0;
      end else begin
        tgt = free ? free_idx : old_idx;
        for (int i = 0; i < NUM_VOICES; i++)
          if (act_d[i] && IDX_W'(i) != tgt && age_d[i] != AGE_MAX)
            age_d[i] = age_d[i] + AGE_W'(1);
        act_d[tgt]  = 1'b1;
        note_d[tgt] = note_on_code;
        age_d[tgt]  = '0;
      end
    end
    for (int i = 0; i < NUM_VOICES; i++)
      cnt_d = cnt_d + (IDX_W+1)'(act_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q  <= '0;
      note_q <= '0;
      age_q  <= '0;
      cnt_q  <= '0;
    end else if (enable) begin
      act_q  <= act_d;
      note_q <= note_d;
      age_q  <= age_d;
      cnt_q  <= cnt_d;
    end
  end

  assign voice_note   = note_q;
  assign voice_active = act_q;
  assign active_count = cnt_q;
endmodule

// File: rtl/poly_voice_mixer.sv
// Polyphonic voice allocator plus two-stage mixer with a ready/valid output.
//   CLOCK_50, reset (sync, active-high), enable (freeze when low)
//   note_on/off strobes + codes -> voice_allocator
//   voice_note/voice_active/active_count : allocator state
//   voice_wave : per-voice samples returned from the external waveform_gen
//                instances, packed like voice_note
//   out_data/out_valid/out_ready : mixed sample stream
// The waveform_gen instances live outside this block: voice_note leaves
// through a port and their samples come back on voice_wave.
module poly_voice_mixer import synth_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int MIX_MODE   = MIX_FIXED
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           note_on,
  input  logic [NOTE_W-1:0]              note_on_code,
  input  logic                           note_off,
  input  logic [NOTE_W-1:0]              note_off_code,
  output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_wave,
  output logic [SAMPLE_W-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_VOICES):0]    active_count
);
  localparam int LV     = $clog2(NUM_VOICES);
  localparam int SUM_W  = SAMPLE_W + LV;
  localparam int STAGES = 1;
  localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  voice_allocator #(.NUM_VOICES(NUM_VOICES), .NOTE_W(NOTE_W)) u_alloc (
    .clk          (CLOCK_50),
    .reset        (reset),
    .enable       (enable),
    .note_on      (note_on),
    .note_on_code (note_on_code),
    .note_off     (note_off),
    .note_off_code(note_off_code),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .active_count (active_count)
  );

  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] wave;
  logic [SUM_W-1:0]                    sum_d, s1_sum;
  logic [LV:0]                         s1_cnt;
  logic signed [SUM_W-1:0]             shifted;
  logic [LV:0]                         upper;
  logic [SAMPLE_W-1:0]                 mix_d;
  logic [STAGES:0]                     vld_pipe;
  int                                  sh;

  assign wave = voice_wave;

  // Stage 1: sign-extended sum of active voices; SUM_W bits cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (voice_active[i])
        sum_d = sum_d + {{LV{wave[i][SAMPLE_W-1]}}, wave[i]};
  end

  // Stage 2: attenuate, then clamp. The clamp only matters in adaptive mode;
  // with a fixed shift of LV the result always fits.
  always_comb begin
    sh      = (MIX_MODE == MIX_ADAPTIVE) ? adaptive_shift(int'(s1_cnt)) : LV;
    shifted = $signed(s1_sum) >>> sh;
    upper   = shifted[SUM_W-1:SAMPLE_W-1];
    if (upper != '0 && upper != '1)
      mix_d = shifted[SUM_W-1] ? SAT_MIN : SAT_MAX;
    else
      mix_d = shifted[SAMPLE_W-1:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_sum   <= '0;
      s1_cnt   <= '0;
      out_data <= '0;
      vld_pipe <= '0;
    end else if (enable) begin
      s1_sum   <= sum_d;
      s1_cnt   <= active_count;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      if (!out_valid || out_ready) out_data <= mix_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_poly_voice_mixer.sv
// Randomized and directed bench for poly_voice_mixer; one instance in fixed
// mix mode, one in adaptive mode, both fed the same stimulus.
module tb_poly_voice_mixer;
  localparam int N  = 4;
  localparam int SW = 32;
  localparam int NW = 5;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1, enable = 1'b1, out_ready = 1'b1;
  logic              note_on = 1'b0, note_off = 1'b0;
  logic [NW-1:0]     note_on_code = '0, note_off_code = '0;
  logic [N*SW-1:0]   voice_wave = '0;
  logic [N*NW-1:0]   vn0, vn1;
  logic [N-1:0]      va0, va1;
  logic [SW-1:0]     od0, od1;
  logic              ov0, ov1;
  logic [2:0]        ac0, ac1;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit   [N-1:0]  m_act = '0;
  logic [NW-1:0] m_note [N];
  int            m_age  [N];
  longint        m_s1 = 0;
  int            m_s1c = 0;
  logic [SW-1:0] m_out0 = '0, m_out1 = '0;
  bit            m_v1 = 0, m_vo = 0;

  poly_voice_mixer #(.NUM_VOICES(N), .SAMPLE_W(SW), .NOTE_W(NW), .MIX_MODE(0)) dut0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
    .note_on(note_on), .note_on_code(note_on_code),
    .note_off(note_off), .note_off_code(note_off_code),
    .voice_note(vn0), .voice_active(va0), .voice_wave(voice_wave),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .active_count(ac0));

  poly_voice_mixer #(.NUM_VOICES(N), .SAMPLE_W(SW), .NOTE_W(NW), .MIX_MODE(1)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
    .note_on(note_on), .note_on_code(note_on_code),
    .note_off(note_off), .note_off_code(note_off_code),
    .voice_note(vn1), .voice_active(va1), .voice_wave(voice_wave),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .active_count(ac1));

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: compute the model's next state from the inputs now
  // applied, clock the DUTs, then compare everything.
  task automatic step();
    bit   [N-1:0]  na;
    logic [NW-1:0] nn [N];
    int            ng [N];
    longint        acc, v, ns1;
    int            ns1c, cnt, sh, hit, tgt;
    logic [SW-1:0] no0, no1;
    bit            nv1, nvo;
    logic [N*NW-1:0] evn;
    na = m_act; nn = m_note; ng = m_age;
    ns1 = m_s1; ns1c = m_s1c; no0 = m_out0; no1 = m_out1; nv1 = m_v1; nvo = m_vo;
    if (reset) begin
      na = '0;
      for (int i = 0; i < N; i++) begin nn[i] = '0; ng[i] = 0; end
      ns1 = 0; ns1c = 0; no0 = '0; no1 = '0; nv1 = 0; nvo = 0;
    end else if (enable) begin
      acc = 0; cnt = 0;
      for (int i = 0; i < N; i++)
        if (m_act[i]) begin
          acc += longint'($signed(voice_wave[i*SW +: SW]));
          cnt++;
        end
      ns1 = acc; ns1c = cnt;
      if (!m_vo || out_ready) begin
        v = m_s1 >>> 2;
        no0 = v[SW-1:0];
        sh = 0;
        while ((1 << sh) < ((m_s1c < 1) ? 1 : m_s1c)) sh++;
        v = m_s1 >>> sh;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        else if (v < -64'sd2147483648) v = -64'sd2147483648;
        no1 = v[SW-1:0];
      end
      nvo = m_v1; nv1 = 1;
      if (note_off && note_off_code != 0)
        for (int i = 0; i < N; i++)
          if (na[i] && nn[i] == note_off_code) begin na[i] = 0; nn[i] = '0; ng[i] = 0; end
      if (note_on && note_on_code != 0) begin
        hit = -1;
        for (int i = 0; i < N; i++)
          if (hit < 0 && na[i] && nn[i] == note_on_code) hit = i;
        if (hit >= 0) ng[hit] = 0;
        else begin
          tgt = -1;
          for (int i = 0; i < N; i++) if (tgt < 0 && !na[i]) tgt = i;
          if (tgt < 0) begin
            tgt = 0;
            for (int i = 1; i < N; i++) if (ng[i] > ng[tgt]) tgt = i;
          end
          for (int i = 0; i < N; i++) if (na[i] && i != tgt && ng[i] < 7) ng[i]++;
          na[tgt] = 1; nn[tgt] = note_on_code; ng[tgt] = 0;
        end
      end
    end
    @(posedge CLOCK_50);
    #1;
    m_act = na; m_note = nn; m_age = ng;
    m_s1 = ns1; m_s1c = ns1c; m_out0 = no0; m_out1 = no1; m_v1 = nv1; m_vo = nvo;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      evn[i*NW +: NW] = m_note[i];
      if (m_act[i]) cnt++;
    end
    chk("voice_active", 64'(va0), 64'(m_act));
    chk("voice_note",   64'(vn0), 64'(evn));
    chk("active_count", 64'(ac0), 64'(cnt));
    chk("voice_note_m1", 64'(vn1), 64'(evn));
    chk("out_valid",    64'(ov0), 64'(m_vo));
    chk("out_valid_m1", 64'(ov1), 64'(m_vo));
    chk("out_data_m0",  64'(od0), 64'(m_out0));
    chk("out_data_m1",  64'(od1), 64'(m_out1));
  endtask

  task automatic idle(input int n);
    note_on = 0; note_off = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic play(input int code);
    note_on = 1; note_on_code = NW'(code); step(); note_on = 0;
  endtask

  task automatic do_reset();
    note_on = 0; note_off = 0; reset = 1; step(); reset = 0;
  endtask

  logic [SW-1:0]   held;
  logic [N*NW-1:0] exp_vn;

  initial begin
    for (int i = 0; i < N; i++) begin m_note[i] = '0; m_age[i] = 0; end
    do_reset();
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_voice_active", 64'(va0), 64'd0);
    idle(2);

    // three notes into the lowest free voices
    play(12); play(14); play(16);
    exp_vn = {5'd0, 5'd16, 5'd14, 5'd12};
    chk("three_notes_vn", 64'(vn0), 64'(exp_vn));
    chk("three_notes_va", 64'(va0), 64'b0111);
    chk("three_notes_cnt", 64'(ac0), 64'd3);
    play(14);                           // retrigger: no new voice
    chk("retrig_va", 64'(va0), 64'b0111);

    // steal the oldest voice
    do_reset();
    play(1); play(2); play(3); play(4); play(5);
    chk("steal_v0", 64'(vn0[4:0]), 64'd5);
    chk("steal_va", 64'(va0), 64'b1111);
    play(6);                            // voice 1 is now oldest
    chk("steal_v1", 64'(vn0[9:5]), 64'd6);

    // same-cycle off/on reuses the freed voice
    do_reset();
    play(1); play(2);
    note_off = 1; note_off_code = 5'd1; note_on = 1; note_on_code = 5'd7;
    step();
    note_off = 0; note_on = 0;
    chk("offon_v0", 64'(vn0[4:0]), 64'd7);
    chk("offon_cnt", 64'(ac0), 64'd2);
    note_off = 1; note_off_code = 5'd0; step(); note_off = 0;   // rest code ignored
    chk("off_rest", 64'(ac0), 64'd2);

    // mixer: 4 voices at 0x4000_0000
    do_reset();
    play(1); play(2); play(3); play(4);
    voice_wave = {N{32'h4000_0000}};
    idle(2);
    chk("mix4_m0", 64'(od0), 64'h4000_0000);
    chk("mix4_m1", 64'(od1), 64'h4000_0000);

    // adaptive: 2 voices at max positive
    do_reset();
    play(1); play(2);
    voice_wave = {N{32'h7FFF_FFFF}};
    idle(2);
    chk("mix2_max_m1", 64'(od1), 64'h7FFF_FFFF);

    // adaptive: 1 voice at max negative
    do_reset();
    play(3);
    voice_wave = {N{32'h8000_0000}};
    idle(2);
    chk("mix1_min_m1", 64'(od1), 64'h8000_0000);
    chk("mix1_min_m0", 64'(od0), 64'hE000_0000);

    // backpressure: output holds while inputs change
    out_ready = 0;
    held = od0;
    for (int k = 0; k < 5; k++) begin
      voice_wave = (k == 4) ? {N{32'h1000_0000}} : {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("stall_hold", 64'(od0), 64'(held));
    end
    out_ready = 1;
    step();
    chk("stall_release", 64'(od0), 64'h0400_0000);

    // reset mid-operation with 3 voices busy
    do_reset();
    play(1); play(2); play(3);
    voice_wave = {N{32'h0123_4567}};
    note_on = 1; note_on_code = 5'd4; reset = 1;
    step();
    reset = 0; note_on = 0;
    chk("midrst_va", 64'(va0), 64'd0);
    chk("midrst_valid", 64'(ov0), 64'd0);
    chk("midrst_data", 64'(od0), 64'd0);
    play(1); play(2); play(3);
    note_off = 1; note_off_code = 5'd9; step(); note_off = 0;
    exp_vn = {5'd0, 5'd3, 5'd2, 5'd1};
    chk("off_unheld", 64'(vn0), 64'(exp_vn));

    // random phase
    for (int k = 0; k < 600; k++) begin
      reset         = ($urandom_range(0, 59) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      out_ready     = ($urandom_range(0, 9) < 7);
      note_on       = $urandom_range(0, 1);
      note_on_code  = NW'($urandom_range(0, 7));
      note_off      = ($urandom_range(0, 2) == 0);
      note_off_code = NW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: voice_wave = {N{32'h7FFF_FFFF}};
        1: voice_wave = {N{32'h8000_0000}};
        default: voice_wave = {$urandom, $urandom, $urandom, $urandom};
      endcase
      step();
    end
    reset = 0; enable = 1; note_on = 0; note_off = 0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/poly_voice_mixer.md
POLY_VOICE_MIXER -- requirements
Module: poly_voice_mixer

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of voices, power of two, 2..16.
REQ-002 Parameter SAMPLE_W, default 32: signed two's-complement sample width.
REQ-003 Parameter NOTE_W, default 5: note code width; code 0 is rest.
REQ-004 Parameter MIX_MODE, default 0: 0 is fixed attenuation; 1 is adaptive attenuation by active-voice count.
REQ-005 CLOCK_50  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  when low, all state freezes; outputs hold.
REQ-008 note_on  in  1  one-cycle strobe: start note_on_code.
REQ-009 note_on_code  in  NOTE_W  note to start.
REQ-010 note_off  in  1  one-cycle strobe: release note_off_code.
REQ-011 note_off_code  in  NOTE_W  note to release.
REQ-012 voice_note  out  NUM_VOICES*NOTE_W  per-voice note for the waveform_gen instances; voice i is at bits [i*NOTE_W +: NOTE_W].
REQ-013 voice_active  out  NUM_VOICES  per-voice busy mask.
REQ-014 voice_wave  in  NUM_VOICES*SAMPLE_W  per-voice samples returned from the generators, packed the same way as voice_note.
REQ-015 out_data  out  SAMPLE_W  mixed sample.
REQ-016 out_valid  out  1  out_data holds a sample.
REQ-017 out_ready  in  1  consumer accepts; tie to audio_out_allowed.
REQ-018 active_count  out  clog2(NUM_VOICES)+1  number of busy voices.

Function
REQ-019 A note_on or note_off with code 0 is ignored.
REQ-020 When note_on and note_off arrive in the same cycle, the allocator processes note_off first and note_on second, so the freed voice can be reused in that cycle.
REQ-021 note_off for a held note clears voice_active and voice_note of every voice holding it; note_off for a note that is not held is ignored.
REQ-022 note_on for a note already held does not allocate a new voice; that voice's age resets to 0.
REQ-023 Otherwise, note_on takes the lowest-index free voice.
REQ-024 If no voice is free, note_on steals the voice with the greatest age; ties go to the lowest index.
REQ-025 Each voice has a saturating age counter of clog2(NUM_VOICES)+1 bits; on every accepted allocation, all other active voices increment and the allocated voice resets to 0.
REQ-026 voice_note, voice_active and active_count update 1 cycle after the strobe; an inactive voice always shows voice_note = 0.
REQ-027 Mix stage 1 (registered): sum of the sign-extended voice_wave of active voices only, in SAMPLE_W+clog2(NUM_VOICES) bits; no overflow is possible.
REQ-028 Mix stage 2, MIX_MODE 0: arithmetic right shift by clog2(NUM_VOICES).
REQ-029 Mix stage 2, MIX_MODE 1: arithmetic right shift by ceil(log2(max(active_count,1))), then saturate to SAMPLE_W (0x7FFF_FFFF / 0x8000_0000 for SAMPLE_W=32).
REQ-030 Output register loads the stage-2 result when !out_valid or out_ready.
REQ-031 out_valid rises 2 cycles after the first enabled cycle following reset and then stays high.
REQ-032 While out_valid && !out_ready, out_data stays stable.
REQ-033 Latency from a voice_wave change to out_data is 2 cycles when out_ready is held high.
REQ-034 Zero active voices yields out_data = 0.

Reset
REQ-035 On reset: voice_active = 0; voice_note = 0; all ages = 0; active_count = 0; pipeline registers = 0; out_data = 0; out_valid = 0.
REQ-036 Reset asserted mid-operation discards pending strobes and in-flight samples in the same edge.
REQ-037 Reset has priority over enable.

Structure
REQ-038 Shared package synth_pkg holds NOTE_REST = 0, the default SAMPLE_W and NOTE_W, and the MIX_MODE encodings (MIX_FIXED = 0, MIX_ADAPTIVE = 1).
REQ-039 Allocation logic (REQ-019..REQ-026) is one sub-module, voice_allocator; the mixer and output register stay in poly_voice_mixer.
REQ-040 The top level instantiates NUM_VOICES waveform_gen instances between voice_note and voice_wave; these instances are outside this block.

Verification (NUM_VOICES=4, SAMPLE_W=32, MIX_MODE 0 unless stated)
REQ-041 note_on 12, 14, 16 on separate cycles -> voice_note = {0,16,14,12} with voice 0 in the LSB slice; voice_active = 4'b0111; active_count = 3.
REQ-042 Notes 1, 2, 3, 4 held, then note_on 5 -> voice 0 (oldest) becomes 5; voice_active = 4'b1111.
REQ-043 Voices 0 and 1 active, note_on 7 together with note_off of voice 0's note in the same cycle -> voice 0 becomes 7; active_count = 2.
REQ-044 All 4 voices active with voice_wave = 0x4000_0000 each -> out_data = 0x4000_0000 two cycles later. MIX_MODE 1, 2 voices at 0x7FFF_FFFF -> out_data = 0x7FFF_FFFF. MIX_MODE 1, 1 voice at 0x8000_0000 -> out_data = 0x8000_0000.
REQ-045 out_ready low for 5 cycles while inputs change -> out_data is constant throughout; the first sample after out_ready rises reflects the current inputs.
REQ-046 Reset pulsed with 3 voices active -> next cycle voice_active = 0, out_valid = 0, out_data = 0; note_off 9 with 9 not held -> no state change.
